// File: rtl/inta_sequencer.sv
// inta_sequencer: INT/INTA handshake for the 8259A in 8086 mode.
// Owns the In-Service Register, emits the vector byte on INTA2 and
// applies automatic or OCW2-commanded end-of-interrupt clears.
module inta_sequencer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT_request,
  input  logic [2:0] serviced_interrupt_index,
  input  logic [2:0] zeroLevelPriorityBit,
  input  logic       INTA_n,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       ocw2_wr,
  input  logic [7:0] OCW2,
  output logic       INT,
  output logic       freezing,
  output logic       INT_requestAck,
  output logic [7:0] ISR_reg,
  output logic       irr_clr,
  output logic [2:0] irr_clr_index,
  output logic [2:0] resetedISR_index,
  output logic       isr_clr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACK1 = 3'd2,
    S_GAP  = 3'd3,
    S_ACK2 = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   inta_prev_q;
  logic                   inta_s;
  logic                   inta_fall;
  logic                   inta_rise;

  logic       int_q, int_d;
  logic       frz_q, frz_d;
  logic       ack_q, ack_d;
  logic       irrclr_q, irrclr_d;
  logic [2:0] irridx_q, irridx_d;
  logic [2:0] idx_q, idx_d;
  logic       spur_q, spur_d;
  logic [7:0] dout_q, dout_d;
  logic       doe_q, doe_d;
  logic [7:0] isr_q, isr_d;
  logic       isrclr_q, isrclr_d;
  logic [2:0] rstidx_q, rstidx_d;

  logic [7:0] set_mask;
  logic       aeoi_clr;
  logic       eoi_clr;
  logic [2:0] eoi_idx;
  logic [2:0] pos;

  assign inta_s    = sync_q[SYNC_STAGES-1];
  assign inta_fall = inta_prev_q & ~inta_s;
  assign inta_rise = ~inta_prev_q & inta_s;

  // Synchronise INTA_n and keep the previous synchronised level for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '1;
      inta_prev_q <= 1'b1;
    end else begin
      sync_q      <= (sync_q << 1) | SYNC_STAGES'(INTA_n);
      inta_prev_q <= inta_s;
    end
  end

  // Decode OCW2 end-of-interrupt commands into a single ISR bit to clear
  always_comb begin
    eoi_clr = 1'b0;
    eoi_idx = '0;
    pos     = '0;
    if (ocw2_wr) begin
      case (OCW2[7:5])
        3'b001, 3'b101: begin
          for (int unsigned k = 0; k < 8; k++) begin
            pos = zeroLevelPriorityBit + 3'(k);
            if (!eoi_clr && isr_q[pos]) begin
              eoi_clr = 1'b1;
              eoi_idx = pos;
            end
          end
        end
        3'b011, 3'b111: begin
          eoi_clr = 1'b1;
          eoi_idx = OCW2[2:0];
        end
        default: ;
      endcase
    end
  end

  // INTA handshake state machine and next-state of all registered outputs
  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    frz_d    = frz_q;
    ack_d    = 1'b0;
    irrclr_d = 1'b0;
    irridx_d = irridx_q;
    idx_d    = idx_q;
    spur_d   = spur_q;
    dout_d   = dout_q;
    doe_d    = doe_q;
    set_mask = '0;
    aeoi_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (INT_request) begin
          int_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (inta_fall) begin
          frz_d   = 1'b1;
          int_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = S_ACK1;
          if (INT_request) begin
            idx_d    = serviced_interrupt_index;
            spur_d   = 1'b0;
            set_mask = 8'b1 << serviced_interrupt_index;
            irrclr_d = 1'b1;
            irridx_d = serviced_interrupt_index;
          end else begin
            idx_d  = 3'd7;
            spur_d = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (inta_rise) state_d = S_GAP;
      end
      S_GAP: begin
        if (inta_fall) begin
          dout_d  = {vector_base, idx_q};
          doe_d   = 1'b1;
          state_d = S_ACK2;
        end
      end
      S_ACK2: begin
        if (inta_rise) begin
          doe_d    = 1'b0;
          frz_d    = 1'b0;
          aeoi_clr = aeoi & ~spur_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Merge ISR clears and sets; a same-cycle set beats any clear of that bit
  always_comb begin
    isr_d = isr_q;
    if (eoi_clr)  isr_d = isr_d & ~(8'b1 << eoi_idx);
    if (aeoi_clr) isr_d = isr_d & ~(8'b1 << idx_q);
    isr_d    = isr_d | set_mask;
    isrclr_d = eoi_clr | aeoi_clr;
    rstidx_d = rstidx_q;
    if (aeoi_clr)     rstidx_d = idx_q;
    else if (eoi_clr) rstidx_d = eoi_idx;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      int_q    <= 1'b0;
      frz_q    <= 1'b0;
      ack_q    <= 1'b0;
      irrclr_q <= 1'b0;
      irridx_q <= '0;
      idx_q    <= '0;
      spur_q   <= 1'b0;
      dout_q   <= '0;
      doe_q    <= 1'b0;
      isr_q    <= '0;
      isrclr_q <= 1'b0;
      rstidx_q <= '0;
    end else begin
      state_q  <= state_d;
      int_q    <= int_d;
      frz_q    <= frz_d;
      ack_q    <= ack_d;
      irrclr_q <= irrclr_d;
      irridx_q <= irridx_d;
      idx_q    <= idx_d;
      spur_q   <= spur_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
      isr_q    <= isr_d;
      isrclr_q <= isrclr_d;
      rstidx_q <= rstidx_d;
    end
  end

  assign INT              = int_q;
  assign freezing         = frz_q;
  assign INT_requestAck   = ack_q;
  assign ISR_reg          = isr_q;
  assign irr_clr          = irrclr_q;
  assign irr_clr_index    = irridx_q;
  assign resetedISR_index = rstidx_q;
  assign isr_clr          = isrclr_q;
  assign data_out         = dout_q;
  assign data_oe          = doe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed and random INTA sequences, with
// pulse/vector expectations queued by stimulus and popped by a monitor.
module tb_inta_sequencer;

  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       INT_request;
  logic [2:0] serviced_interrupt_index;
  logic [2:0] zeroLevelPriorityBit;
  logic       INTA_n;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       ocw2_wr;
  logic [7:0] OCW2;
  logic       INT;
  logic       freezing;
  logic       INT_requestAck;
  logic [7:0] ISR_reg;
  logic       irr_clr;
  logic [2:0] irr_clr_index;
  logic [2:0] resetedISR_index;
  logic       isr_clr;
  logic [7:0] data_out;
  logic       data_oe;

  always #5 clk = ~clk;

  inta_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .INT_request              (INT_request),
    .serviced_interrupt_index (serviced_interrupt_index),
    .zeroLevelPriorityBit     (zeroLevelPriorityBit),
    .INTA_n                   (INTA_n),
    .vector_base              (vector_base),
    .aeoi                     (aeoi),
    .ocw2_wr                  (ocw2_wr),
    .OCW2                     (OCW2),
    .INT                      (INT),
    .freezing                 (freezing),
    .INT_requestAck           (INT_requestAck),
    .ISR_reg                  (ISR_reg),
    .irr_clr                  (irr_clr),
    .irr_clr_index            (irr_clr_index),
    .resetedISR_index         (resetedISR_index),
    .isr_clr                  (isr_clr),
    .data_out                 (data_out),
    .data_oe                  (data_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_isr;
  logic [7:0] exp_vec_q[$];
  logic [2:0] exp_irr_q[$];
  logic [2:0] exp_isr_q[$];
  int         exp_acks = 0;
  int         seen_acks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a pulse or vector
  initial begin : monitor
    logic prev_oe;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (data_oe && !prev_oe) begin
          chk("vector_expected", 32'(exp_vec_q.size() != 0), 1);
          if (exp_vec_q.size() != 0) chk("vector_byte", data_out, exp_vec_q.pop_front());
        end
        if (irr_clr) begin
          chk("irr_clr_expected", 32'(exp_irr_q.size() != 0), 1);
          if (exp_irr_q.size() != 0) chk("irr_clr_index", irr_clr_index, exp_irr_q.pop_front());
        end
        if (isr_clr) begin
          chk("isr_clr_expected", 32'(exp_isr_q.size() != 0), 1);
          if (exp_isr_q.size() != 0) chk("resetedISR_index", resetedISR_index, exp_isr_q.pop_front());
        end
        if (INT_requestAck) seen_acks++;
      end
      prev_oe = data_oe;
    end
  end

  // Full two-pulse INTA sequence; optionally spurious or with a colliding specific EOI
  task automatic do_seq(input logic [2:0] idx, input logic [4:0] vb, input bit ae,
                        input bit spur, input bit collide);
    vector_base = vb;
    aeoi = ae;
    serviced_interrupt_index = idx;
    INT_request = 1'b1;
    cyc(2);
    chk("int_assert", INT, 1);
    if (spur) begin
      INT_request = 1'b0;
      cyc(2);
      chk("int_held", INT, 1);
    end
    exp_acks++;
    if (!spur) exp_irr_q.push_back(idx);
    INTA_n = 1'b0;
    if (collide) begin
      cyc(2);
      OCW2 = {3'b011, 2'b00, idx};
      ocw2_wr = 1'b1;
      model_isr[idx] = 1'b0;
      exp_isr_q.push_back(idx);
      cyc(1);
      ocw2_wr = 1'b0;
      cyc(1);
    end else begin
      cyc(4);
    end
    if (!spur) model_isr[idx] = 1'b1;
    INT_request = 1'b0;
    chk("freeze_ack1", freezing, 1);
    chk("int_drop", INT, 0);
    chk("isr_at_ack1", ISR_reg, model_isr);
    INTA_n = 1'b1;
    cyc(4);
    chk("oe_gap", data_oe, 0);
    chk("freeze_gap", freezing, 1);
    exp_vec_q.push_back({vb, spur ? 3'd7 : idx});
    INTA_n = 1'b0;
    cyc(4);
    chk("oe_ack2", data_oe, 1);
    INTA_n = 1'b1;
    if (ae && !spur) begin
      model_isr[idx] = 1'b0;
      exp_isr_q.push_back(idx);
    end
    cyc(4);
    chk("oe_done", data_oe, 0);
    chk("freeze_done", freezing, 0);
    chk("int_idle", INT, 0);
    chk("isr_done", ISR_reg, model_isr);
  endtask

  // OCW2 write with the model applying the EOI rules
  task automatic eoi(input logic [7:0] cmd, input logic [2:0] zlp);
    zeroLevelPriorityBit = zlp;
    OCW2 = cmd;
    ocw2_wr = 1'b1;
    case (cmd[7:5])
      3'b001, 3'b101: begin
        for (int k = 0; k < 8; k++) begin
          int p;
          p = (int'(zlp) + k) % 8;
          if (model_isr[p]) begin
            model_isr[p] = 1'b0;
            exp_isr_q.push_back(3'(p));
            break;
          end
        end
      end
      3'b011, 3'b111: begin
        model_isr[cmd[2:0]] = 1'b0;
        exp_isr_q.push_back(cmd[2:0]);
      end
      default: ;
    endcase
    cyc(1);
    ocw2_wr = 1'b0;
    cyc(1);
    chk("isr_after_eoi", ISR_reg, model_isr);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    INT_request = 1'b0;
    serviced_interrupt_index = '0;
    zeroLevelPriorityBit = '0;
    INTA_n = 1'b1;
    vector_base = '0;
    aeoi = 1'b0;
    ocw2_wr = 1'b0;
    OCW2 = '0;
    model_isr = '0;
    cyc(3);
    chk("rst_INT", INT, 0);
    chk("rst_freezing", freezing, 0);
    chk("rst_ack", INT_requestAck, 0);
    chk("rst_isr", ISR_reg, 0);
    chk("rst_irr_clr", irr_clr, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_isr_clr", isr_clr, 0);
    reset = 1'b0;
    cyc(2);

    // Basic sequence, then AEOI, then spurious
    do_seq(3'd3, 5'b01000, 1'b0, 1'b0, 1'b0);
    chk("basic_isr", ISR_reg, 8'h08);
    do_seq(3'd3, 5'b01000, 1'b1, 1'b0, 1'b0);
    chk("aeoi_isr", ISR_reg, 8'h00);
    do_seq(3'd4, 5'b10101, 1'b0, 1'b1, 1'b0);
    chk("spurious_isr", ISR_reg, 8'h00);

    // EOI priority cases
    do_seq(3'd2, 5'b00001, 1'b0, 1'b0, 1'b0);
    do_seq(3'd5, 5'b00001, 1'b0, 1'b0, 1'b0);
    chk("isr_24", ISR_reg, 8'h24);
    eoi(8'h20, 3'd0);
    chk("ns_eoi_z0", ISR_reg, 8'h20);
    do_seq(3'd2, 5'b00001, 1'b0, 1'b0, 1'b0);
    eoi(8'h20, 3'd3);
    chk("ns_eoi_z3", ISR_reg, 8'h04);
    do_seq(3'd5, 5'b00001, 1'b0, 1'b0, 1'b0);
    eoi(8'h65, 3'd0);
    chk("spec_eoi5", ISR_reg, 8'h04);
    eoi(8'h62, 3'd0);
    eoi(8'h20, 3'd0);
    chk("ns_eoi_empty", ISR_reg, 8'h00);
    eoi(8'hC0, 3'd0);

    // Specific EOI colliding with the INTA1 set of the same bit
    do_seq(3'd3, 5'b11110, 1'b0, 1'b0, 1'b1);
    chk("collide_bit3", 32'(ISR_reg[3]), 1);
    eoi(8'h63, 3'd0);

    // Reset asserted while in GAP
    vector_base = 5'b10011;
    serviced_interrupt_index = 3'd6;
    INT_request = 1'b1;
    cyc(2);
    exp_acks++;
    exp_irr_q.push_back(3'd6);
    INTA_n = 1'b0;
    cyc(4);
    INT_request = 1'b0;
    INTA_n = 1'b1;
    cyc(4);
    chk("gap_freeze", freezing, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_INT", INT, 0);
    chk("midrst_freezing", freezing, 0);
    chk("midrst_isr", ISR_reg, 0);
    chk("midrst_data_oe", data_oe, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_irr_idx", irr_clr_index, 0);
    model_isr = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(2);
    INTA_n = 1'b0;
    cyc(4);
    chk("post_rst_oe_low", data_oe, 0);
    INTA_n = 1'b1;
    cyc(4);
    chk("post_rst_oe_high", data_oe, 0);
    chk("post_rst_freeze", freezing, 0);

    // Randomised sequences interleaved with random OCW2 commands
    for (int it = 0; it < 30; it++) begin
      logic [2:0] ridx;
      logic [4:0] rvb;
      ridx = 3'($urandom_range(0, 7));
      rvb  = 5'($urandom);
      do_seq(ridx, rvb, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 1'b0);
      if ($urandom_range(0, 1) == 1) eoi(8'($urandom), 3'($urandom_range(0, 7)));
    end

    cyc(5);
    chk("vec_queue_drained", exp_vec_q.size(), 0);
    chk("irr_queue_drained", exp_irr_q.size(), 0);
    chk("isr_queue_drained", exp_isr_q.size(), 0);
    chk("ack_count", seen_acks, exp_acks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

Downstream companion of the priority resolver in the 8259A PIC. Converts the resolver's `INT_request`/`serviced_interrupt_index` into the CPU-facing INT line and the two-pulse 8086-mode INTA sequence. It owns the In-Service Register and handles automatic and OCW2-commanded EOI. It drives `freezing`, `ISR_reg`, `resetedISR_index` and `INT_requestAck` back into the resolver, drives the vector byte onto the data bus, and tells the IRR which bit to clear.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `INTA_n` before edge detection; must be ≥1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `INT_request`  in  1  resolver: an unmasked IRR bit outranks the ISR.
- `serviced_interrupt_index`  in  3  resolver: winning IR index.
- `zeroLevelPriorityBit`  in  3  resolver: index currently holding highest priority.
- `INTA_n`  in  1  CPU interrupt acknowledge, active-low, asynchronous to `clk`.
- `vector_base`  in  5  ICW2 bits T7..T3.
- `aeoi`  in  1  ICW4 AEOI bit.
- `ocw2_wr`  in  1  one-cycle strobe: `OCW2` holds a newly written command.
- `OCW2`  in  8  OCW2 command byte: R, SL, EOI in bits 7:5; L2..L0 in bits 2:0.
- `INT`  out  1  interrupt line to the CPU.
- `freezing`  out  1  holds the resolver and IRR while an INTA sequence is in progress.
- `INT_requestAck`  out  1  one-cycle pulse when a request is captured at INTA1.
- `ISR_reg`  out  8  In-Service Register.
- `irr_clr`  out  1  one-cycle pulse: clear IRR bit `irr_clr_index`.
- `irr_clr_index`  out  3  IRR bit to clear.
- `resetedISR_index`  out  3  index of the most recently cleared ISR bit; holds its value between clears.
- `isr_clr`  out  1  one-cycle pulse each time an ISR bit is cleared.
- `data_out`  out  8  vector byte.
- `data_oe`  out  1  drive enable for `data_out`.

## Operation
- **Reset values:** all outputs are 0; state is IDLE.
- **INTA edge detection:** `inta_s` is `INTA_n` after SYNC_STAGES flops. A fall is `inta_s` going from 1 to 0; a rise is `inta_s` going from 0 to 1.
- **IDLE:**
  - `INT_request`=1 → REQ; `INT`←1.
  - An INTA fall while in IDLE is ignored.
- **REQ:**
  - On an INTA fall: `freezing`←1, `INT`←0, `INT_requestAck` pulses, index captured → ACK1.
  - If `INT_request`=1 at that fall: captured index = `serviced_interrupt_index`; set `ISR_reg`[index]; `irr_clr` pulses with that index.
  - If `INT_request`=0 at that fall (spurious): captured index = 7; ISR and IRR are not touched.
  - If `INT_request` drops while in REQ, `INT` stays 1 until INTA arrives.
- **ACK1:** INTA rise → GAP.
- **GAP:** INTA fall → `data_out`←{`vector_base`, index}; `data_oe`←1 → ACK2.
- **ACK2:** INTA rise:
  - `data_oe`←0; `freezing`←0.
  - If `aeoi`=1 and not spurious: clear `ISR_reg`[index], pulse `isr_clr`, `resetedISR_index`←index.
  - → IDLE. `INT` may reassert on the following cycle.
- **EOI commands:** accepted in any state on `ocw2_wr`. Behaviour by OCW2[7:5]:
  - 001 and 101 (non-specific EOI): clear the highest-priority set ISR bit, scanning from `zeroLevelPriorityBit` upward modulo 8. If ISR is empty, nothing happens and no `isr_clr` pulse is issued.
  - 011 and 111 (specific EOI): clear ISR bit L2..L0. `isr_clr` pulses even if that bit was already 0.
  - 000, 010, 100, 110: no ISR action here; rotation is handled in the resolver.
- **Simultaneous events:**
  - An EOI clear and an INTA1 set of the same bit in the same cycle: the set wins.
  - Different bits: both apply.
  - An AEOI clear and an OCW2 clear in the same cycle: both bits clear; `resetedISR_index` reports the AEOI index.
- **Reset mid-sequence:** the state machine, ISR and `data_oe` drop immediately (asynchronously). The CPU's remaining INTA pulses are ignored until the next REQ.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- `INT` rises 1 cycle after `INT_request` is sampled 1.
- INTA edge to output change: the output updates on clock edge SYNC_STAGES+1 after the first edge that samples the new `INTA_n` level.
- `ISR_reg` set, `irr_clr` and `freezing` all appear on the same edge.
- `INT_requestAck`, `irr_clr` and `isr_clr` are exactly 1 cycle wide.
- `data_oe` stays high from the recognised INTA2 fall to the recognised INTA2 rise.
- OCW2 EOI takes effect on the edge that samples `ocw2_wr`=1, i.e. `ISR_reg` updates 1 cycle later.

## Test plan
- **Basic sequence:** `vector_base`=5'b01000, `aeoi`=0, resolver presents index 3 with `INT_request`=1, CPU issues two INTA pulses → `INT` 1 then 0; `ISR_reg`=8'h08; one `irr_clr` pulse with index 3; `data_out`=8'h43 with `data_oe`=1 only during INTA2; `freezing` high from INTA1 fall to INTA2 rise.
- **AEOI:** same as the basic sequence with `aeoi`=1 → after the INTA2 rise, `ISR_reg`=8'h00, `isr_clr` pulses once, `resetedISR_index`=3.
- **Spurious:** drop `INT_request` before the INTA1 fall → `data_out`={`vector_base`, 3'd7}; `ISR_reg` unchanged; no `irr_clr` pulse.
- **EOI priority:**
  - ISR=8'h24, `zeroLevelPriorityBit`=0, OCW2=8'h20 → ISR=8'h20, `resetedISR_index`=2.
  - ISR=8'h24, `zeroLevelPriorityBit`=3, OCW2=8'h20 → ISR=8'h04.
  - OCW2=8'h65 → bit 5 cleared.
  - OCW2=8'h20 with ISR=0 → no `isr_clr` pulse.
- **Collision and reset:**
  - Specific EOI for bit 3 written on the same edge as the INTA1 set of bit 3 → ISR bit 3 ends at 1.
  - `reset` asserted during GAP → all outputs 0 immediately; a subsequent INTA pulse produces no `data_oe`.
